// File: rtl/mux41_structural_pkg.sv
// Shared constants for the structural 4:1 multiplexer slice.
package mux_pkg;

  localparam int unsigned MUX41_N_IN  = 4;
  localparam int unsigned MUX41_SEL_W = 2;

  typedef enum logic [MUX41_SEL_W-1:0] {
    SEL_A0 = 2'd0,
    SEL_A1 = 2'd1,
    SEL_A2 = 2'd2,
    SEL_A3 = 2'd3
  } sel_e;

endpackage

// File: rtl/mux41_structural_if.sv
// Bundle of the mux data/select/result signals for benches and wrappers.
interface mux41_structural_if;
  import mux_pkg::*;

  logic [MUX41_N_IN-1:0]  a;
  logic [MUX41_SEL_W-1:0] s;
  logic                   c;
  logic                   c_q;

  modport master (output a, s, input  c, c_q);
  modport slave  (input  a, s, output c, c_q);

endinterface

// File: rtl/mux41_structural_mux21_gate.sv
// 2:1 multiplexer built only from not/and/or primitives.
module mux21_gate (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  logic nsel;
  logic p0;
  logic p1;

  not u_not  (nsel, sel);
  and u_and0 (p0, d0, nsel);
  and u_and1 (p1, d1, sel);
  or  u_or   (y, p0, p1);

endmodule

// File: rtl/mux41_structural.sv
// Structural 4:1 single-bit mux with a synchronously reset registered copy.
// Plain ports keep the legacy positional order a, s, c, clk, rst, c_q.
module mux41_structural
  import mux_pkg::*;
(
  input  logic [MUX41_N_IN-1:0]  a,
  input  logic [MUX41_SEL_W-1:0] s,
  output logic                   c,
  input  logic                   clk,
  input  logic                   rst,
  output logic                   c_q
);

  logic m_lo;
  logic m_hi;

  // Two-level tree: s[0] picks within each pair, s[1] picks the pair.
  mux21_gate u_mux_lo (.d0(a[0]), .d1(a[1]), .sel(s[0]), .y(m_lo));
  mux21_gate u_mux_hi (.d0(a[2]), .d1(a[3]), .sel(s[0]), .y(m_hi));
  mux21_gate u_mux_out(.d0(m_lo), .d1(m_hi), .sel(s[1]), .y(c));

  always_ff @(posedge clk) begin
    if (rst) c_q <= 1'b0;
    else     c_q <= c;
  end

endmodule

// File: tb/tb_mux41_structural.sv
// Scoreboard bench for mux41_structural: queued expectations, separate monitors.
`timescale 1ps/1ps
module tb_mux41_structural;
  import mux_pkg::*;

  typedef struct {
    string name;
    logic  exp;
  } item_t;

  logic        clk    = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst    = 1'b1;
  string       cur_tag = "idle";
  item_t       comb_q[$];
  item_t       reg_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  mux41_structural_if bus();

  mux41_structural dut (
    .a  (bus.a),
    .s  (bus.s),
    .c  (bus.c),
    .clk(clk),
    .rst(rst),
    .c_q(bus.c_q)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  // Reference: the selected bit is the one shifted down to position 0.
  function automatic logic model(logic [3:0] av, logic [1:0] sv);
    logic [3:0] sh;
    sh = av >> int'(sv);
    return sh[0];
  endfunction

  task automatic check(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(logic [3:0] av, logic [1:0] sv, string name);
    item_t it;
    bus.a = av;
    bus.s = sv;
    it.name = name;
    it.exp  = model(av, sv);
    comb_q.push_back(it);
  endtask

  task automatic apply_exp(logic [3:0] av, logic [1:0] sv, logic exp, string name);
    item_t it;
    bus.a = av;
    bus.s = sv;
    it.name = name;
    it.exp  = exp;
    comb_q.push_back(it);
  endtask

  // Combinational monitor: settle 1ps after each issued stimulus, then compare c.
  initial begin
    item_t it;
    forever begin
      wait (comb_q.size() != 0);
      #1;
      while (comb_q.size() != 0) begin
        it = comb_q.pop_front();
        check({it.name, "_c"}, bus.c, it.exp);
      end
    end
  end

  // Register model: what c_q must show after this edge.
  always @(posedge clk) begin
    item_t it;
    if (clk_en) begin
      it.name = cur_tag;
      it.exp  = rst ? 1'b0 : model(bus.a, bus.s);
      reg_q.push_back(it);
    end
  end

  // Register monitor: c_q sampled on the falling edge.
  always @(negedge clk) begin
    item_t it;
    if (reg_q.size() != 0) begin
      it = reg_q.pop_front();
      check({it.name, "_cq"}, bus.c_q, it.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] in;
    logic [3:0] av;
    logic [1:0] sv;

    bus.a = '0;
    bus.s = '0;

    // Unclocked exhaustive sweep
    for (int i = 0; i < 64; i++) begin
      in = 6'(i);
      apply(in[3:0], in[5:4], "sweep");
      #2;
    end

    apply_exp(4'b0100, 2'b10, 1'b1, "spot0"); #2;
    apply_exp(4'b0100, 2'b01, 1'b0, "spot1"); #2;
    apply_exp(4'b1000, 2'b11, 1'b1, "spot2"); #2;
    apply_exp(4'b0111, 2'b11, 1'b0, "spot3"); #2;
    apply_exp(4'b1xx0, 2'b11, 1'b1, "x_iso3"); #2;
    apply_exp(4'b1xx0, 2'b00, 1'b0, "x_iso0"); #2;

    // Reset held over two edges with all-ones data
    rst = 1'b1;
    apply_exp(4'b1111, 2'b10, 1'b1, "rst_hold");
    cur_tag = "rst_hold";
    #2;
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cur_tag = "rst_release";

    // Latency: select moves just after edge k
    @(negedge clk);
    apply_exp(4'b0001, 2'b00, 1'b1, "lat_k");
    cur_tag = "lat_k";
    @(posedge clk);
    #1;
    apply_exp(4'b0001, 2'b01, 1'b0, "lat_k1");
    cur_tag = "lat_k1";

    // Random traffic with occasional mid-stream reset
    repeat (300) begin
      @(negedge clk);
      av  = 4'($urandom_range(0, 15));
      sv  = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 7) == 0);
      apply(av, sv, "rand");
      cur_tag = rst ? "rand_rst" : "rand";
    end

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clk_en = 1'b0;
    #30;
    check("drain", (comb_q.size() == 0 && reg_q.size() == 0), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
